// File: rtl/floating_point_divider_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : floating_point_divider_seq_if
//  Description : Operand/result handshake bundle for the iterative FP32
//                divider. Optional flags field exists only when
//                FP_DIV_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface floating_point_divider_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
`ifdef FP_DIV_FLAGS_EN
    logic [3:0]  flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, flags
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, flags
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res
    );
`endif
endinterface
`default_nettype wire

// File: rtl/floating_point_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : floating_point_divider_seq
//  Description : Iterative IEEE-754 single-precision divider (res = a / b).
//                Restoring long division producing QBITS quotient bits per
//                clock (26/QBITS DIV cycles), one NORM/round cycle, then the
//                result is held until the consumer accepts it.
//                Optional feature macro: FP_DIV_FLAGS_EN adds a 4-bit flags
//                output {exception, div_by_zero, overflow, underflow}.
//  Revision    : 1.0 - initial release
// ============================================================================
module floating_point_divider_seq #(
    parameter int QBITS = 1            // legal values: 1, 2, 13
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    floating_point_divider_seq_if.slave bus
);

    localparam int         C_N    = 26 / QBITS;
    localparam logic [4:0] C_LAST = 5'(C_N - 1);

    localparam logic [1:0] C_S_IDLE = 2'd0;
    localparam logic [1:0] C_S_DIV  = 2'd1;
    localparam logic [1:0] C_S_NORM = 2'd2;
    localparam logic [1:0] C_S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [25:0] rem_q;
    logic [25:0] quot_q;
    logic [23:0] opb_q;
    logic [4:0]  cnt_q;
    logic        sign_q;
    logic [9:0]  exp_q;
    logic [31:0] res_q;

    // Operand decode used at the accept edge
    logic [7:0]  w_ea, w_eb;
    logic        w_accept, w_sign, w_exc, w_a_zero, w_b_zero, w_special;
    logic [31:0] w_special_res;

    assign w_ea      = bus.a[30:23];
    assign w_eb      = bus.b[30:23];
    assign w_accept  = bus.in_valid & (state_q == C_S_IDLE);
    assign w_sign    = bus.a[31] ^ bus.b[31];
    assign w_exc     = (w_ea == 8'hFF) | (w_eb == 8'hFF);
    // Denormals are flushed, so any zero exponent counts as a zero operand.
    assign w_a_zero  = (w_ea == 8'd0);
    assign w_b_zero  = (w_eb == 8'd0);
    assign w_special = w_exc | w_a_zero | w_b_zero;

    // Special-case result in priority order: exception, divide by zero, zero dividend
    always_comb begin
        if (w_exc)
            w_special_res = 32'h0000_0000;
        else if (w_b_zero)
            w_special_res = {w_sign, 8'hFF, 23'd0};
        else
            w_special_res = {w_sign, 31'd0};
    end

    // QBITS restoring-division steps unrolled into one cycle
    logic [25:0] w_rem_step, w_quot_step;
    always_comb begin
        w_rem_step  = rem_q;
        w_quot_step = quot_q;
        for (int k = 0; k < QBITS; k++) begin
            if (w_rem_step >= {2'b00, opb_q}) begin
                w_quot_step = {w_quot_step[24:0], 1'b1};
                w_rem_step  = w_rem_step - {2'b00, opb_q};
            end else begin
                w_quot_step = {w_quot_step[24:0], 1'b0};
            end
            w_rem_step = {w_rem_step[24:0], 1'b0};
        end
    end

    // Normalise, round (up iff guard & sticky) and range-check the quotient
    logic        w_q25, w_guard, w_sticky, w_carry, w_ovf, w_unf;
    logic [22:0] w_mant_raw, w_mant;
    logic [23:0] w_mant_sum;
    logic [9:0]  w_exp_n;
    logic [31:0] w_norm_res;
    always_comb begin
        w_q25      = quot_q[25];
        w_mant_raw = w_q25 ? quot_q[24:2] : quot_q[23:1];
        w_guard    = w_q25 ? quot_q[1] : quot_q[0];
        w_sticky   = (w_q25 & quot_q[0]) | (rem_q != 26'd0);
        w_mant_sum = {1'b0, w_mant_raw} + {23'd0, w_guard & w_sticky};
        w_carry    = w_mant_sum[23];
        w_mant     = w_carry ? 23'd0 : w_mant_sum[22:0];
        w_exp_n    = exp_q - {9'd0, ~w_q25} + {9'd0, w_carry};
        // exp is 10-bit two's complement: bit 9 set means negative
        w_ovf      = ~w_exp_n[9] & (w_exp_n >= 10'd255);
        w_unf      = w_exp_n[9] | (w_exp_n == 10'd0);
        if (w_ovf)
            w_norm_res = {sign_q, 8'hFF, 23'd0};
        else if (w_unf)
            w_norm_res = {sign_q, 31'd0};
        else
            w_norm_res = {sign_q, w_exp_n[7:0], w_mant};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= C_S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_S_IDLE: if (w_accept) state_d = w_special ? C_S_DONE : C_S_DIV;
            C_S_DIV:  if (cnt_q == C_LAST) state_d = C_S_NORM;
            C_S_NORM: state_d = C_S_DONE;
            C_S_DONE: if (bus.out_ready) state_d = C_S_IDLE;
            default:  state_d = C_S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state_q == C_S_IDLE);
        bus.out_valid = (state_q == C_S_DONE);
    end

    assign bus.res = res_q;

    // Datapath: capture on accept, iterate in DIV, round in NORM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= 26'd0;
            quot_q <= 26'd0;
            opb_q  <= 24'd0;
            cnt_q  <= 5'd0;
            sign_q <= 1'b0;
            exp_q  <= 10'd0;
            res_q  <= 32'd0;
        end else begin
            case (state_q)
                C_S_IDLE: begin
                    if (w_accept) begin
                        sign_q <= w_sign;
                        opb_q  <= {1'b1, bus.b[22:0]};
                        rem_q  <= {2'b01, bus.a[22:0]};
                        quot_q <= 26'd0;
                        cnt_q  <= 5'd0;
                        exp_q  <= {2'b00, w_ea} - {2'b00, w_eb} + 10'd127;
                        if (w_special)
                            res_q <= w_special_res;
                    end
                end
                C_S_DIV: begin
                    rem_q  <= w_rem_step;
                    quot_q <= w_quot_step;
                    cnt_q  <= cnt_q + 5'd1;
                end
                C_S_NORM: res_q <= w_norm_res;
                default: ;
            endcase
        end
    end

`ifdef FP_DIV_FLAGS_EN
    logic [3:0] flags_q;
    logic       w_denorm;
    assign w_denorm = ((w_ea == 8'd0) & (bus.a[22:0] != 23'd0)) |
                      ((w_eb == 8'd0) & (bus.b[22:0] != 23'd0));

    // Status flags follow res: set at accept for special cases, in NORM otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'd0;
        end else if (w_accept && w_special) begin
            if (w_exc)
                flags_q <= 4'b1000;
            else
                flags_q <= {1'b0, w_b_zero & ~w_a_zero, 1'b0, w_denorm};
        end else if (state_q == C_S_NORM) begin
            flags_q <= {2'b00, w_ovf, w_unf};
        end
    end

    assign bus.flags = flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_floating_point_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floating_point_divider_seq
//  Description : Scoreboard bench for floating_point_divider_seq. Three DUTs
//                (QBITS = 1, 2, 13) share one stimulus stream; each has its
//                own expected-result queue and monitor, which also checks
//                accept-to-valid latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floating_point_divider_seq;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        bit          spec;
        int          acc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        drv_in_valid  = 1'b0;
    logic        drv_out_ready = 1'b1;
    logic [31:0] drv_a = 32'd0;
    logic [31:0] drv_b = 32'd0;

    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [31:0] res_v   [3];
    logic [3:0]  flags_v [3];

    exp_t exp_q [3][$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar I = 0; I < 3; I++) begin : g_dut
        localparam int QB = (I == 0) ? 1 : ((I == 1) ? 2 : 13);

        floating_point_divider_seq_if u_if ();

        assign u_if.in_valid  = drv_in_valid;
        assign u_if.a         = drv_a;
        assign u_if.b         = drv_b;
        assign u_if.out_ready = drv_out_ready;
        assign in_ready_v[I]  = u_if.in_ready;
        assign out_valid_v[I] = u_if.out_valid;
        assign res_v[I]       = u_if.res;
`ifdef FP_DIV_FLAGS_EN
        assign flags_v[I]     = u_if.flags;
`else
        assign flags_v[I]     = 4'd0;
`endif

        floating_point_divider_seq #(.QBITS(QB)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if.slave)
        );

        // Monitor: pop and compare the first cycle each result is presented
        initial begin : p_mon
            bit   seen;
            exp_t e;
            int   lat;
            seen = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    seen = 1'b0;
                end else if (out_valid_v[I] && !seen) begin
                    seen = 1'b1;
                    checks++;
                    if (exp_q[I].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result q=%0d res=%h", QB, res_v[I]);
                    end else begin
                        e   = exp_q[I].pop_front();
                        lat = cyc - e.acc;
                        if (res_v[I] !== e.res) begin
                            errors++;
                            $display("FAIL res q=%0d got=%h exp=%h", QB, res_v[I], e.res);
                        end
                        checks++;
                        if (lat != (e.spec ? 0 : (26 / QB + 1))) begin
                            errors++;
                            $display("FAIL latency q=%0d got=%0d exp=%0d", QB, lat,
                                     e.spec ? 0 : (26 / QB + 1));
                        end
`ifdef FP_DIV_FLAGS_EN
                        checks++;
                        if (flags_v[I] !== e.flags) begin
                            errors++;
                            $display("FAIL flags q=%0d got=%b exp=%b", QB, flags_v[I], e.flags);
                        end
`endif
                    end
                end else if (!out_valid_v[I]) begin
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    // Present one operand pair, push expectations for the instances in mask
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] er, input logic [3:0] ef,
                         input bit spec, input logic [2:0] mask);
        exp_t e;
        drv_a        = ta;
        drv_b        = tb_v;
        drv_in_valid = 1'b1;
        @(posedge clk);
        #1;
        drv_in_valid = 1'b0;
        drv_a        = 32'hFFFF_FFFF;
        drv_b        = 32'h3F80_0000;
        e.res   = er;
        e.flags = ef;
        e.spec  = spec;
        e.acc   = cyc;
        for (int i = 0; i < 3; i++)
            if (mask[i]) exp_q[i].push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (in_ready_v != 3'b111 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_idle timeout in_ready=%b", in_ready_v);
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] er, input logic [3:0] ef, input bit spec);
        issue(ta, tb_v, er, ef, spec, 3'b111);
        wait_idle();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {29'd0, in_ready_v}, 32'h7);
        check("reset_out_valid", {29'd0, out_valid_v}, 32'h0);
        check("reset_res0", res_v[0], 32'h0);
        check("reset_res2", res_v[2], 32'h0);
`ifdef FP_DIV_FLAGS_EN
        check("reset_flags", {28'd0, flags_v[0]}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //      a             b             res           flags    special
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0); // 6/2
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b0); // 1/3 round up
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1'b1); // 1/0
        run_op(32'h7F800000, 32'h3F800000, 32'h00000000, 4'b1000, 1'b1); // inf dividend
        run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 1'b0); // overflow
        run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 1'b0); // -6/2
        run_op(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1'b1); // -0/2
        run_op(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0001, 1'b1); // denormal a
        run_op(32'h3F800000, 32'h00000001, 32'h7F800000, 4'b0101, 1'b1); // denormal b
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 1'b0); // underflow
        run_op(32'h3F800000, 32'h7E800000, 32'h00800000, 4'b0000, 1'b0); // min normal
        run_op(32'h00000000, 32'h00000000, 32'h7F800000, 4'b0000, 1'b1); // 0/0
        run_op(32'h3F800000, 32'h7FC00000, 32'h00000000, 4'b1000, 1'b1); // NaN divisor
        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 1'b0); // 1/1
        run_op(32'h40400000, 32'hC0000000, 32'hBFC00000, 4'b0000, 1'b0); // 3/-2

        // Backpressure: result must hold while out_ready is low
        drv_out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0, 3'b111);
        n = 0;
        while (out_valid_v != 3'b111 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_wait_valid", {29'd0, out_valid_v}, 32'h7);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {29'd0, out_valid_v}, 32'h7);
            check("bp_in_ready", {29'd0, in_ready_v}, 32'h0);
            check("bp_res0", res_v[0], 32'h40400000);
            check("bp_res1", res_v[1], 32'h40400000);
            check("bp_res2", res_v[2], 32'h40400000);
        end
        drv_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {29'd0, in_ready_v}, 32'h7);
        check("bp_release_out_valid", {29'd0, out_valid_v}, 32'h0);
        check("bp_res_hold", res_v[0], 32'h40400000);

        // Reset abort: QBITS=13 finishes before cycle 10, the others are lost
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b0, 3'b100);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {29'd0, out_valid_v}, 32'h0);
        check("abort_in_ready", {29'd0, in_ready_v}, 32'h7);
        check("abort_res0", res_v[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0);

        repeat (3) @(posedge clk);
        for (int i = 0; i < 3; i++)
            check("queue_drained", exp_q[i].size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
